// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson-code monitors.
package johnson_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  // Index width for a WIDTH-stage Johnson code (2*WIDTH states).
  function automatic int jc_idx_w(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational legality check and decode of one Johnson code word.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int  WIDTH  = 4,
  localparam int IDX_W  = jc_idx_w(WIDTH),
  localparam int STATES = 2 * WIDTH,
  localparam int CNT_W  = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]  jc_in,
  output logic              legal,
  output logic [IDX_W-1:0]  idx,
  output logic [STATES-1:0] onehot
);

  logic [WIDTH-2:0] w_edges;
  logic [CNT_W-1:0] w_trans;
  logic [CNT_W-1:0] w_ones;

  // A legal word has at most one boundary between its run of ones and zeros.
  assign w_edges = jc_in[WIDTH-1:1] ^ jc_in[WIDTH-2:0];

  always_comb begin
    w_trans = '0;
    w_ones  = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      w_trans = w_trans + CNT_W'(w_edges[i]);
    end
    for (int i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + CNT_W'(jc_in[i]);
    end
  end

  assign legal = (w_trans <= CNT_W'(1));

  always_comb begin
    if (jc_in[WIDTH-1] || (w_ones == '0)) begin
      idx = IDX_W'(w_ones);
    end else begin
      idx = IDX_W'(STATES - int'(w_ones));
    end
  end

  generate
    for (genvar gi = 0; gi < STATES; gi++) begin : g_onehot
      assign onehot[gi] = legal && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code bus monitor: decode, sequence check, lock FSM and error counter.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int  WIDTH      = 4,
  parameter int  LOCK_COUNT = 3,
  parameter int  ERR_W      = 8,
  localparam int IDX_W      = jc_idx_w(WIDTH),
  localparam int STATES     = 2 * WIDTH,
  localparam int RUN_W      = $clog2(LOCK_COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  jc_in,
  input  logic              clr_err,
  output logic [IDX_W-1:0]  idx,
  output logic [STATES-1:0] onehot,
  output logic              valid,
  output logic              illegal,
  output logic              step_err,
  output logic              locked,
  output logic [ERR_W-1:0]  err_count
);

  lock_state_t       r_state;
  lock_state_t       w_state_next;
  logic [RUN_W-1:0]  r_run;
  logic [RUN_W-1:0]  w_run_next;
  logic [IDX_W-1:0]  r_idx;
  logic [STATES-1:0] r_onehot;
  logic              r_valid;
  logic              r_illegal;
  logic              r_step_err;
  logic [ERR_W-1:0]  r_err_count;

  logic              w_legal;
  logic [IDX_W-1:0]  w_idx;
  logic [STATES-1:0] w_onehot;
  logic [IDX_W-1:0]  w_prev_inc;
  logic              w_in_seq;
  logic              w_step;
  logic              w_err;

  johnson_code_check #(.WIDTH(WIDTH)) u_check (
    .jc_in  (jc_in),
    .legal  (w_legal),
    .idx    (w_idx),
    .onehot (w_onehot)
  );

  // r_idx always holds the last legal sample, so it doubles as prev.
  assign w_prev_inc = (r_idx == IDX_W'(STATES - 1)) ? '0 : r_idx + IDX_W'(1);
  assign w_in_seq   = w_legal && (w_idx == w_prev_inc);
  assign w_step     = en && w_legal && (r_state != UNLOCKED) && !w_in_seq;
  assign w_err      = en && (!w_legal || w_step);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= UNLOCKED;
      r_run   <= '0;
    end else begin
      r_state <= w_state_next;
      r_run   <= w_run_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_run_next   = r_run;
    if (en) begin
      case (r_state)
        UNLOCKED: begin
          if (w_legal) begin
            w_state_next = ACQUIRE;
            w_run_next   = RUN_W'(1);
          end
        end
        ACQUIRE: begin
          if (!w_legal) begin
            w_state_next = UNLOCKED;
            w_run_next   = '0;
          end else if (w_in_seq) begin
            w_run_next = r_run + RUN_W'(1);
            if (r_run == RUN_W'(LOCK_COUNT - 1)) begin
              w_state_next = LOCKED;
            end
          end else begin
            w_run_next = RUN_W'(1);
          end
        end
        LOCKED: begin
          if (!w_in_seq) begin
            w_state_next = UNLOCKED;
            w_run_next   = '0;
          end
        end
        default: begin
          w_state_next = UNLOCKED;
          w_run_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    locked = (r_state == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_onehot   <= '0;
      r_valid    <= 1'b0;
      r_illegal  <= 1'b0;
      r_step_err <= 1'b0;
    end else begin
      r_valid    <= en && w_legal;
      r_illegal  <= en && !w_legal;
      r_step_err <= w_step;
      if (en && w_legal) begin
        r_idx    <= w_idx;
        r_onehot <= w_onehot;
      end
    end
  end

  // A clear coinciding with a fresh error leaves that error counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (clr_err) begin
      r_err_count <= ERR_W'(w_err);
    end else if (w_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERR_W'(1);
    end
  end

  assign idx       = r_idx;
  assign onehot    = r_onehot;
  assign valid     = r_valid;
  assign illegal   = r_illegal;
  assign step_err  = r_step_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_johnson_decoder.sv
// Randomized and directed self-checking bench for johnson_decoder (WIDTH=4).
module tb_johnson_decoder;

  localparam int LC = 3;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] jc_in;
  logic       clr_err;

  logic [2:0] idx, idx2;
  logic [7:0] onehot, onehot2;
  logic       valid, valid2, illegal, illegal2, step_err, step_err2, locked, locked2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;

  johnson_decoder #(.WIDTH(4), .LOCK_COUNT(LC), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .jc_in(jc_in), .clr_err(clr_err),
    .idx(idx), .onehot(onehot), .valid(valid), .illegal(illegal),
    .step_err(step_err), .locked(locked), .err_count(err_count)
  );

  johnson_decoder #(.WIDTH(4), .LOCK_COUNT(LC), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .jc_in(jc_in), .clr_err(clr_err),
    .idx(idx2), .onehot(onehot2), .valid(valid2), .illegal(illegal2),
    .step_err(step_err2), .locked(locked2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [24:0] obs;
  assign obs = {idx, onehot, valid, illegal, step_err, locked, err_count, err_count2};

  // Reference model state
  int m_idx, m_streak, m_err, m_err2;
  bit m_seen, m_locked, m_valid, m_ill, m_step;

  // The k-th Johnson word: ones fill in from the MSB, then drain from the MSB.
  function automatic logic [3:0] jc_code(input int k);
    if (k < 4) return 4'(((1 << k) - 1) << (4 - k));
    return 4'((1 << (8 - k)) - 1);
  endfunction

  function automatic int jc_lookup(input logic [3:0] c);
    for (int k = 0; k < 8; k++) if (jc_code(k) == c) return k;
    return -1;
  endfunction

  function automatic logic [24:0] expv();
    return {3'(m_idx), m_seen ? 8'(1 << m_idx) : 8'h00, m_valid, m_ill, m_step,
            m_locked, 8'(m_err), 2'(m_err2)};
  endfunction

  task automatic model_update(input logic e, input logic [3:0] c, input logic clr, input logic r);
    int k;
    bit err;
    if (r) begin
      m_idx = 0; m_seen = 0; m_streak = 0; m_locked = 0;
      m_err = 0; m_err2 = 0; m_valid = 0; m_ill = 0; m_step = 0;
      return;
    end
    m_valid = 0; m_ill = 0; m_step = 0;
    if (e) begin
      k = jc_lookup(c);
      if (k < 0) begin
        m_ill = 1; m_streak = 0; m_locked = 0;
      end else begin
        m_valid = 1;
        if (m_streak == 0) m_streak = 1;
        else if (k == (m_idx + 1) % 8) begin
          if (!m_locked) begin
            m_streak++;
            if (m_streak == LC) m_locked = 1;
          end
        end else begin
          m_step = 1;
          if (m_locked) begin m_locked = 0; m_streak = 0; end
          else m_streak = 1;
        end
        m_idx = k; m_seen = 1;
      end
    end
    err = m_ill || m_step;
    if (clr) begin
      m_err = err ? 1 : 0; m_err2 = err ? 1 : 0;
    end else if (err) begin
      m_err  = (m_err < 255) ? m_err + 1 : 255;
      m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
    end
  endtask

  task automatic tick(input logic e, input logic [3:0] c, input logic clr, input logic r);
    en = e; jc_in = c; clr_err = clr; rst = r;
    @(posedge clk);
    #1;
    model_update(e, c, clr, r);
    $display("txn rst=%0b en=%0b jc=%b clr=%0b -> idx=%0d oh=%b v=%0b ill=%0b se=%0b lk=%0b err=%0d/%0d",
             r, e, c, clr, idx, onehot, valid, illegal, step_err, locked, err_count, err_count2);
  endtask

  task automatic test_reset();
    tick(1'b1, 4'b1100, 1'b1, 1'b1);
    tick(1'b1, 4'b1010, 1'b0, 1'b1);
    checks++;
    if (obs !== 25'd0) begin
      errors++; $display("FAIL reset: got %h expected 0", obs);
    end
  endtask

  task automatic test_sequence_lock();
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, jc_code(i % 8), 1'b0, 1'b0);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL seq_model: got %h expected %h", obs, expv());
      end
      checks++;
      if ({idx, valid, locked, err_count} !== {3'(i % 8), 1'b1, 1'(i >= 2), 8'd0}) begin
        errors++;
        $display("FAIL seq_lock[%0d]: got idx=%0d v=%0b lk=%0b err=%0d expected idx=%0d v=1 lk=%0b err=0",
                 i, idx, valid, locked, err_count, i % 8, i >= 2);
      end
    end
  endtask

  task automatic test_wrap();
    int k;
    for (int j = 0; j < 8; j++) begin
      k = (2 + j) % 8;
      tick(1'b1, jc_code(k), 1'b0, 1'b0);
      checks++;
      if ({idx, step_err, locked} !== {3'(k), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL wrap[%0d]: got idx=%0d se=%0b lk=%0b expected idx=%0d se=0 lk=1",
                 j, idx, step_err, locked, k);
      end
    end
  endtask

  task automatic test_illegal();
    tick(1'b1, jc_code(2), 1'b0, 1'b0);
    tick(1'b1, 4'b1010, 1'b0, 1'b0);
    checks++;
    if ({illegal, valid, idx, locked, err_count} !== {1'b1, 1'b0, 3'd2, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL illegal: got ill=%0b v=%0b idx=%0d lk=%0b err=%0d expected ill=1 v=0 idx=2 lk=0 err=1",
               illegal, valid, idx, locked, err_count);
    end
    for (int j = 0; j < 3; j++) begin
      tick(1'b1, jc_code(3 + j), 1'b0, 1'b0);
      checks++;
      if ({idx, locked} !== {3'(3 + j), 1'(j == 2)}) begin
        errors++;
        $display("FAIL relock[%0d]: got idx=%0d lk=%0b expected idx=%0d lk=%0b",
                 j, idx, locked, 3 + j, j == 2);
      end
    end
  endtask

  task automatic test_skip();
    for (int j = 0; j < 5; j++) tick(1'b1, jc_code((6 + j) % 8), 1'b0, 1'b0);
    checks++;
    if ({idx, locked} !== {3'd2, 1'b1}) begin
      errors++; $display("FAIL skip_pre: got idx=%0d lk=%0b expected idx=2 lk=1", idx, locked);
    end
    tick(1'b1, 4'b1111, 1'b0, 1'b0);
    checks++;
    if ({step_err, idx, locked, err_count} !== {1'b1, 3'd4, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL skip: got se=%0b idx=%0d lk=%0b err=%0d expected se=1 idx=4 lk=0 err=2",
               step_err, idx, locked, err_count);
    end
  endtask

  task automatic test_en_gaps();
    for (int j = 5; j < 8; j++) tick(1'b1, jc_code(j), 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      tick(1'b1, jc_code(s), 1'b0, 1'b0);
      checks++;
      if ({idx, valid, locked} !== {3'(s), 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL gap_sample[%0d]: got idx=%0d v=%0b lk=%0b expected idx=%0d v=1 lk=1",
                 s, idx, valid, locked, s);
      end
      for (int g = 0; g < 5; g++) begin
        tick(1'b0, 4'($urandom), 1'b0, 1'b0);
        checks++;
        if ({idx, valid, illegal, step_err, locked, err_count} !== {3'(s), 4'b0001, 8'd2}) begin
          errors++;
          $display("FAIL gap_hold[%0d.%0d]: got idx=%0d v=%0b ill=%0b se=%0b lk=%0b err=%0d expected idx=%0d 0 0 0 lk=1 err=2",
                   s, g, idx, valid, illegal, step_err, locked, err_count, s);
        end
      end
    end
  endtask

  task automatic test_counter_edges();
    tick(1'b0, 4'b0000, 1'b1, 1'b0);
    checks++;
    if ({err_count, err_count2} !== 10'd0) begin
      errors++; $display("FAIL clr: got err=%0d/%0d expected 0/0", err_count, err_count2);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 4'b0101, 1'b0, 1'b0);
      checks++;
      if ({err_count, err_count2} !== {8'(i + 1), 2'((i + 1 > 3) ? 3 : i + 1)}) begin
        errors++;
        $display("FAIL sat[%0d]: got err=%0d/%0d expected %0d/%0d",
                 i, err_count, err_count2, i + 1, (i + 1 > 3) ? 3 : i + 1);
      end
    end
    tick(1'b1, 4'b0101, 1'b1, 1'b0);
    checks++;
    if ({err_count, err_count2} !== {8'd1, 2'd1}) begin
      errors++; $display("FAIL clr_with_err: got err=%0d/%0d expected 1/1", err_count, err_count2);
    end
    for (int j = 0; j < 3; j++) tick(1'b1, jc_code(j), 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL edge_lock: got lk=%0b expected 1", locked);
    end
    tick(1'b1, 4'b0101, 1'b1, 1'b1);
    checks++;
    if (obs !== 25'd0) begin
      errors++; $display("FAIL reset_locked: got %h expected 0", obs);
    end
  endtask

  task automatic test_random();
    int sel;
    logic [3:0] c;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6) c = jc_code((m_idx + 1) % 8);
      else if (sel < 8) c = jc_code($urandom_range(0, 7));
      else c = 4'($urandom);
      tick(1'($urandom_range(0, 3) != 0), c, 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 99) == 0));
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL random[%0d]: got %h expected %h", n, obs, expv());
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; jc_in = 4'b0000; clr_err = 1'b0;
    test_reset();
    test_sequence_lock();
    test_wrap();
    test_illegal();
    test_skip();
    test_en_gaps();
    test_counter_edges();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side monitor for a WIDTH-stage Johnson (twisted-ring) code bus. Each enabled cycle it samples the code, checks it is a legal Johnson word, and decodes it to a binary index and a one-hot vector. It also checks that consecutive samples advance by exactly one state, and keeps a lock state machine plus a saturating error counter. It sits downstream of the team's Johnson counters, either as a self-checking decoder for state-sequenced control or as a bench-independent health monitor.

## Interface
Parameters:
- WIDTH, 4: number of Johnson stages; code has 2*WIDTH states; legal range 2..16
- LOCK_COUNT, 3: consecutive in-sequence legal samples required to lock; legal range 2..15
- ERR_W, 8: width of the error counter

Ports:
- clk  input  1  sole clock; rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  sample-enable; jc_in is evaluated only when en=1
- jc_in  input  WIDTH  Johnson code, MSB = first stage
- clr_err  input  1  synchronous clear of err_count
- idx  output  clog2(2*WIDTH)  decoded state index of last legal sample
- onehot  output  2*WIDTH  one-hot of idx; all-zero until the first legal sample
- valid  output  1  pulse: last enabled sample was legal
- illegal  output  1  pulse: last enabled sample was not a Johnson word
- step_err  output  1  pulse: legal sample, but not prev_idx+1 mod 2*WIDTH (only while ACQUIRE or LOCKED)
- locked  output  1  state == LOCKED
- err_count  output  ERR_W  saturating error count

## Operation
- State sequence (WIDTH=4): idx 0=0000, 1=1000, 2=1100, 3=1110, 4=1111, 5=0111, 6=0011, 7=0001, then back to 0.
- Legality: at most one adjacent-bit change across jc_in[WIDTH-1:0]. Checking n = popcount(jc_in ^ (jc_in>>1)) over the WIDTH-1 adjacent pairs, n ≤ 1.
- Decode for a legal word, with n = popcount(jc_in):
  - if jc_in[WIDTH-1]=1 or n=0, then idx = n
  - otherwise idx = 2*WIDTH − n
- Lock FSM states are UNLOCKED (reset), ACQUIRE and LOCKED. run is a counter in the range 0..LOCK_COUNT.
  - UNLOCKED, legal sample: go to ACQUIRE with run=1, and store idx as prev.
  - UNLOCKED, illegal sample: stay in UNLOCKED.
  - ACQUIRE, in-sequence legal sample: run+1; when run reaches LOCK_COUNT, go to LOCKED.
  - ACQUIRE, out-of-sequence legal sample: step_err; stay in ACQUIRE with run=1 (restart from this sample).
  - ACQUIRE, illegal sample: go to UNLOCKED with run=0.
  - LOCKED, in-sequence legal sample: stay in LOCKED.
  - LOCKED, illegal or out-of-sequence sample: go to UNLOCKED with run=0.
- err_count increments by 1 on every cycle where illegal or step_err is set. It saturates at all-ones; it does not wrap.
- clr_err: err_count ← 0. If an error occurs in the same cycle, err_count ← 1.
- en=0: no pulses; idx, onehot, prev, run and state all hold.
- Holding the same code with en=1 is a step error. Callers gate en to the counter's advance strobe.

## Timing
- All outputs are registered. A sample taken at rising edge k appears on the outputs after edge k.
- Latency is 1 cycle from jc_in to idx, onehot, pulses and err_count.
- locked rises on the same edge that registers the LOCK_COUNT-th in-sequence sample. It falls on the same edge that registers the first error.
- An illegal sample leaves idx and onehot unchanged, and valid=0.
- Wrap-around (idx 2*WIDTH−1 → 0) is in sequence.
- Reset (at any time, including mid-lock) sets the following on the next edge, and rst has priority over en and clr_err:
  - idx=0, onehot=0, valid=illegal=step_err=0
  - locked=0, state=UNLOCKED, run=0
  - err_count=0

## Structure
- Shared package johnson_pkg holds:
  - the lock_state_t enum {UNLOCKED, ACQUIRE, LOCKED}
  - the function jc_idx_w(WIDTH) = clog2(2*WIDTH)
- Sub-module johnson_code_check is purely combinational. It takes jc_in and produces legal, idx and onehot, and is reused by future Johnson monitors.
- The top level holds the sample registers, prev/run, the FSM and the error counter.

## Test plan
- Sequence lock: after rst, drive 0000,1000,1100,1110,… with en=1 every cycle.
  - Required: idx 0,1,2,3,… one cycle later; valid=1 throughout.
  - locked=1 after the 3rd sample registers; err_count=0.
- Wrap: locked, then drive 0011,0001,0000,1000.
  - Required: idx 6,7,0,1; no step_err; locked stays 1.
- Illegal word: locked at idx 2, drive 1010.
  - Required: illegal=1, valid=0, idx holds at 2, locked=0, err_count=1.
  - Then 1110,1111,0111 re-locks on the 3rd sample.
- Skip: locked at 1100, drive 1111.
  - Required: step_err=1, idx=4, locked=0, err_count increments.
- en gaps: counter sequence with en low for 5 cycles between samples.
  - Required: outputs hold through the gap, no pulses, no errors, and locked is retained.
- Counter edges: ERR_W=2, five errors → err_count=3 (saturated); clr_err together with an error → 1.
  - Then rst asserted while locked → all outputs zero after the next edge.
